fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage sitting directly upstream of the next-PC logic. It owns the architectural program-counter register, issues pipelined in-order read requests to instruction memory, buffers returned instructions tagged with their PC, and hands them to decode through a valid/ready handshake. Taken-branch targets produced by the next-PC logic arrive as a redirect that reloads the PC and squashes all younger in-flight fetches.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset
- DEPTH, 2, instruction buffer entries and max in-flight requests (power of two, ≥2)

- CLK  in  1  clock, all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- Redirect  in  1  load RedirectPC, flush stage
- RedirectPC  in  64  new fetch address (branch target)
- CurrentPC  out  64  PC of next request to issue
- ImemReqValid  out  1  request valid
- ImemReqAddr  out  64  request address (= CurrentPC)
- ImemReqReady  in  1  memory accepts request
- ImemRespValid  in  1  response valid, in order, ≥1 cycle after accept, never back-pressured
- ImemRespData  in  32  instruction word
- InstrValid  out  1  buffer head valid
- Instr  out  32  head instruction
- InstrPC  out  64  PC of head instruction
- InstrReady  in  1  decode accepts head
- AlignFault  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- Credit rule: ImemReqValid = !Reset-state & (inflight + occupancy < DEPTH) & !AlignFault. Response space is thus always reserved.
- Request handshake (ImemReqValid & ImemReqReady): CurrentPC <= CurrentPC + 4 (wraps modulo 2^64); address pushed onto an in-flight PC tag queue; inflight += 1.
- Response: pop tag; if drop_cnt > 0, discard and drop_cnt -= 1; else enqueue {ImemRespData, tag} into buffer. inflight -= 1.
- Decode handshake (InstrValid & InstrReady): dequeue head. Buffer may enqueue and dequeue in the same cycle.
- Redirect: CurrentPC <= RedirectPC; buffer flushed except a head consumed that same cycle; drop_cnt <= inflight after same-cycle accept and response. Redirect overrides the +4 increment; a request accepted in the redirect cycle is stale and its response is dropped.
- Redirect while drop_cnt > 0 accumulates correctly (drop_cnt reflects all outstanding).
- Redirect takes priority over every other update in its cycle.

## Timing
- Reset values: CurrentPC = RESET_PC, ImemReqValid = 0, InstrValid = 0, Instr = 0, InstrPC = 0, AlignFault = 0; counters and buffer empty.
- First request on the first rising edge after Reset deasserts (ImemReqValid combinational from registered state).
- Latency: response in cycle N is visible on InstrValid in cycle N+1 (registered buffer), no bypass.
- Redirect in cycle N: ImemReqAddr = RedirectPC in cycle N+1; InstrValid = 0 in N+1.
- Throughput: one instruction per cycle with 1-cycle memory latency and InstrReady held high.
- Reset asserted mid-operation clears everything immediately; responses arriving during or after reset for pre-reset requests are the memory's responsibility to suppress.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: a Redirect with RedirectPC[1:0] != 0 sets AlignFault (sticky until Reset), flushes as normal, and blocks all further requests.
- Undefined: RedirectPC[1:0] is forced to 2'b00; AlignFault tied 0.

## Structure
- Shared package fetch_pkg: ADDR_W = 64, INSTR_W = 32, PC_STEP = 4, buffer entry struct {instr, pc}.
- One sub-module: fetch_buffer, a DEPTH-entry synchronous FIFO with flush, push, pop, count; instantiated twice (tag queue, instruction buffer).

## Test plan
- Reset with RESET_PC = 64'h1000, ready memory, 1-cycle latency, InstrReady = 1 -> InstrPC sequence 1000, 1004, 1008 on consecutive cycles.
- InstrReady = 0 for 5 cycles -> exactly DEPTH (2) requests issued, then ImemReqValid = 0 until a pop.
- Redirect to 64'h2000 with 2 requests in flight -> both responses dropped, next InstrPC = 2000.
- Redirect coincident with request accept and decode pop -> popped instruction delivered once, stale response dropped, ImemReqAddr = target next cycle.
- CurrentPC = 64'hFFFF_FFFF_FFFF_FFFC -> next request address 64'h0.
- With FETCH_ALIGN_CHECK_EN, redirect to 64'h2002 -> AlignFault = 1, no further requests; without, next address 64'h2000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, PC step and the instruction buffer entry layout for the fetch stage.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (see fetch_unit.sv).
package fetch_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  // Low PC bits that must be zero for a word-aligned fetch address
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(PC_STEP - 1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(PC_STEP);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry synchronous FIFO with flush; head data is read combinationally
// from registered storage. DEPTH must be a power of two so pointers wrap freely.
module fetch_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointer/count: flush empties the queue and wins over push and pop
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + PTR_W'(1);
      if (pop_i)  rptr_d = rptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage; cleared on reset so the head reads as zero out of reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order memory requests under a
// credit limit, tags responses with their PC and buffers them for decode.
// FETCH_ALIGN_CHECK_EN: misaligned redirect raises a sticky AlignFault and halts
// fetching; otherwise the redirect target's low bits are forced to zero.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Redirect,
  input  logic [63:0] RedirectPC,
  output logic [63:0] CurrentPC,
  output logic        ImemReqValid,
  output logic [63:0] ImemReqAddr,
  input  logic        ImemReqReady,
  input  logic        ImemRespValid,
  input  logic [31:0] ImemRespData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [63:0] InstrPC,
  input  logic        InstrReady,
  output logic        AlignFault
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  tag_cnt, buf_cnt;
  logic [ADDR_W-1:0] tag_head;
  logic [ADDR_W-1:0] redirect_tgt;
  logic [CNT_W:0]    credit_use;
  fetch_entry_t      buf_wdata, buf_head;
  logic              req_fire, resp_drop, buf_push, instr_pop;

  assign req_fire  = ImemReqValid & ImemReqReady;
  assign resp_drop = ImemRespValid & (drop_q != '0);
  assign instr_pop = InstrValid & InstrReady;
  // A response landing in a redirect cycle belongs to the old path
  assign buf_push  = ImemRespValid & ~resp_drop & ~Redirect;

  // Slots held = in flight + buffered; a head leaving this cycle frees its slot
  // before any new response can arrive, which keeps single-cycle throughput.
  assign credit_use   = {1'b0, tag_cnt} + {1'b0, buf_cnt} - {{CNT_W{1'b0}}, instr_pop};
  assign ImemReqValid = ~Reset & ~AlignFault & (credit_use < (CNT_W + 1)'(DEPTH));

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;

  assign redirect_tgt = RedirectPC;

  // Sticky fault on any misaligned redirect; only reset clears it
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) fault_q <= 1'b0;
    else if (Redirect && ((RedirectPC & ALIGN_MASK) != '0)) fault_q <= 1'b1;
  end

  assign AlignFault = fault_q;
`else
  assign redirect_tgt = RedirectPC & ~ALIGN_MASK;
  assign AlignFault   = 1'b0;
`endif

  // Next PC and drop count; redirect overrides increment and drop decrement,
  // and counts every request still outstanding after this cycle as stale.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (Redirect) begin
      pc_d   = redirect_tgt;
      drop_d = tag_cnt + CNT_W'(req_fire) - CNT_W'(ImemRespValid);
    end else begin
      if (req_fire)  pc_d   = pc_next(pc_q);
      if (resp_drop) drop_d = drop_q - CNT_W'(1);
    end
  end

  // PC and drop-count registers
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  // In-flight PC tags; never flushed, stale entries drain with their responses
  fetch_buffer #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
    .clk_i   (CLK),
    .rst_i   (Reset),
    .flush_i (1'b0),
    .push_i  (req_fire),
    .wdata_i (pc_q),
    .pop_i   (ImemRespValid),
    .rdata_o (tag_head),
    .count_o (tag_cnt)
  );

  assign buf_wdata.instr = ImemRespData;
  assign buf_wdata.pc    = tag_head;

  // Instruction buffer toward decode
  fetch_buffer #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_q (
    .clk_i   (CLK),
    .rst_i   (Reset),
    .flush_i (Redirect),
    .push_i  (buf_push),
    .wdata_i (buf_wdata),
    .pop_i   (instr_pop),
    .rdata_o (buf_head),
    .count_o (buf_cnt)
  );

  assign CurrentPC   = pc_q;
  assign ImemReqAddr = pc_q;
  assign InstrValid  = (buf_cnt != '0);
  assign Instr       = buf_head.instr;
  assign InstrPC     = buf_head.pc;

endmodule
